// File: rtl/regfile_nrw_if.sv
// Decode/writeback-facing bundle of the register file: write ports, reads, reservations.
`timescale 1ns/1ps
interface regfile_nrw_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    localparam int NREG = 2**ADDR_W;

    logic              write_enable_1;
    logic [ADDR_W-1:0] write_addr_1;
    logic [DATA_W-1:0] write_data_1;
    logic              low_byte_only_1;
    logic              write_enable_2;
    logic [ADDR_W-1:0] write_addr_2;
    logic [DATA_W-1:0] write_data_2;
    logic [ADDR_W-1:0] read_addr_1;
    logic [ADDR_W-1:0] read_addr_2;
    logic              reserve_enable;
    logic [ADDR_W-1:0] reserve_addr;
    logic [DATA_W-1:0] read_data_1;
    logic [DATA_W-1:0] read_data_2;
    logic [DATA_W-1:0] read_data_fixed;
    logic              busy_1;
    logic              busy_2;
    logic [NREG-1:0]   pending;
    logic              write_conflict;

    modport master (
        output write_enable_1, write_addr_1, write_data_1, low_byte_only_1,
        output write_enable_2, write_addr_2, write_data_2,
        output read_addr_1, read_addr_2, reserve_enable, reserve_addr,
        input  read_data_1, read_data_2, read_data_fixed,
        input  busy_1, busy_2, pending, write_conflict
    );

    modport slave (
        input  write_enable_1, write_addr_1, write_data_1, low_byte_only_1,
        input  write_enable_2, write_addr_2, write_data_2,
        input  read_addr_1, read_addr_2, reserve_enable, reserve_addr,
        output read_data_1, read_data_2, read_data_fixed,
        output busy_1, busy_2, pending, write_conflict
    );
endinterface

// File: rtl/regfile_nrw.sv
// Dual-write, tri-read register file with write forwarding and a pending scoreboard.
// Latency: reads 1 cycle, writes visible at the same edge via forwarding; no backpressure.
`timescale 1ns/1ps
module regfile_nrw #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 4,
    parameter int FIXED_ADDR = (2**ADDR_W) - 1
) (
    input  logic          clk,
    input  logic          rst,
    regfile_nrw_if.slave  rf
);
    localparam int NREG = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] FIX_A = FIXED_ADDR[ADDR_W-1:0];

    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   pend;
    logic [NREG-1:0]   pend_nxt;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] rdf;
    logic              conf;

    logic [DATA_W-1:0] wv1;
    logic              same_addr;
    logic              we2_eff;

    assign wv1       = rf.low_byte_only_1 ? {{(DATA_W-8){1'b0}}, rf.write_data_1[7:0]}
                                          : rf.write_data_1;
    assign same_addr = rf.write_enable_1 && rf.write_enable_2
                       && (rf.write_addr_1 == rf.write_addr_2);
    // Port 1 wins a same-address collision; port 2's data is dropped.
    assign we2_eff   = rf.write_enable_2 && !same_addr;

    function automatic logic [DATA_W-1:0] fwd(input logic [ADDR_W-1:0] a);
        if (rf.write_enable_1 && rf.write_addr_1 == a)
            return wv1;
        if (we2_eff && rf.write_addr_2 == a)
            return rf.write_data_2;
        return regs[a];
    endfunction

    // Reservation is applied after the write clear so a new producer issuing
    // in the retiring cycle keeps the register marked.
    always_comb begin
        pend_nxt = pend;
        if (rf.write_enable_1)
            pend_nxt[rf.write_addr_1] = 1'b0;
        if (rf.write_enable_2)
            pend_nxt[rf.write_addr_2] = 1'b0;
        if (rf.reserve_enable)
            pend_nxt[rf.reserve_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
            pend <= '0;
            rd1  <= '0;
            rd2  <= '0;
            rdf  <= '0;
            conf <= 1'b0;
        end else begin
            if (rf.write_enable_1)
                regs[rf.write_addr_1] <= wv1;
            if (we2_eff)
                regs[rf.write_addr_2] <= rf.write_data_2;
            pend <= pend_nxt;
            rd1  <= fwd(rf.read_addr_1);
            rd2  <= fwd(rf.read_addr_2);
            rdf  <= fwd(FIX_A);
            conf <= same_addr;
        end
    end

    assign rf.read_data_1     = rd1;
    assign rf.read_data_2     = rd2;
    assign rf.read_data_fixed = rdf;
    assign rf.pending         = pend;
    assign rf.write_conflict  = conf;
    assign rf.busy_1          = pend[rf.read_addr_1];
    assign rf.busy_2          = pend[rf.read_addr_2];
endmodule
